// File: rtl/core_boot_pkg.sv
// -----------------------------------------------------------------------------
// core_boot_pkg
// Shared types and constants for the PULPino boot/supervision sequencer.
//   state_t     : sequencer state encoding (also exported on state_o)
//   TRIP_CNT_W  : width of the saturating watchdog trip counter
//   max_u       : elaboration-time maximum, used to size the sequencing counter
// -----------------------------------------------------------------------------
package core_boot_pkg;

   typedef enum logic [2:0] {
      HOLD  = 3'd0,
      START = 3'd1,
      RUN   = 3'd2,
      LOAD  = 3'd3,
      TRIP  = 3'd4
   } state_t;

   localparam int unsigned TRIP_CNT_W = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/core_boot_ctrl_heartbeat_wdt.sv
// -----------------------------------------------------------------------------
// heartbeat_wdt
// Heartbeat watchdog: counts clk_clk cycles since the last heartbeat edge and
// flags expiry once the count reaches WDT_CYCLES-1 (where it saturates).
// Ports:
//   clk_clk       in  system clock
//   reset_reset_n in  synchronous active-low reset
//   clear         in  holds the counter at zero (sequencer not in RUN)
//   heartbeat_i   in  firmware heartbeat level, same clock domain
//   expired       out counter is saturated at WDT_CYCLES-1
// -----------------------------------------------------------------------------
module heartbeat_wdt #(
   parameter int unsigned WDT_CYCLES = 1000000
) (
   input  logic clk_clk,
   input  logic reset_reset_n,
   input  logic clear,
   input  logic heartbeat_i,
   output logic expired
);

   localparam int unsigned        WDT_W   = $clog2(WDT_CYCLES);
   localparam logic [WDT_W-1:0]   WDT_MAX = WDT_W'(WDT_CYCLES - 1);

   logic             hb_q;
   logic [WDT_W-1:0] wdt_cnt_q;
   logic [WDT_W-1:0] wdt_cnt_d;

   // Next count: restart on clear or on any heartbeat edge, otherwise saturate-count.
   always_comb begin
      wdt_cnt_d = wdt_cnt_q;
      if (clear || (heartbeat_i != hb_q)) begin
         wdt_cnt_d = '0;
      end else if (wdt_cnt_q != WDT_MAX) begin
         wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      end else begin
         wdt_cnt_d = wdt_cnt_q;
      end
   end

   // Heartbeat sample and counter registers.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         hb_q      <= 1'b0;
         wdt_cnt_q <= '0;
      end else begin
         hb_q      <= heartbeat_i;
         wdt_cnt_q <= wdt_cnt_d;
      end
   end

   assign expired = (wdt_cnt_q == WDT_MAX);

endmodule

// File: rtl/core_boot_ctrl.sv
// -----------------------------------------------------------------------------
// core_boot_ctrl
// Boot and supervision sequencer for the PULPino core. Holds the core in reset,
// releases it, enables fetch, parks it while the JTAG loader owns memory, and
// re-boots it when the firmware heartbeat stalls.
// Ports:
//   clk_clk        in  system clock
//   reset_reset_n  in  synchronous active-low reset
//   load_req_i     in  loader requests the core be halted (level)
//   wdt_enable_i   in  allows watchdog expiry to re-boot the core
//   heartbeat_i    in  firmware heartbeat (gpio_out bit)
//   core_rst_n_o   out core reset, active low
//   fetch_enable_o out core fetch enable
//   boot_addr_o    out constant BOOT_ADDR
//   testmode_o     out constant 0
//   clock_gating_o out constant 0
//   state_o        out current state encoding
//   wdt_trip_o     out one-cycle pulse while in TRIP
//   trip_count_o   out saturating watchdog trip count
// -----------------------------------------------------------------------------
module core_boot_ctrl
   import core_boot_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR       = 32'h00008000,
   parameter int unsigned RST_HOLD_CYCLES = 16,
   parameter int unsigned FETCH_DELAY     = 8,
   parameter int unsigned WDT_CYCLES      = 1000000
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic                  load_req_i,
   input  logic                  wdt_enable_i,
   input  logic                  heartbeat_i,
   output logic                  core_rst_n_o,
   output logic                  fetch_enable_o,
   output logic [31:0]           boot_addr_o,
   output logic                  testmode_o,
   output logic                  clock_gating_o,
   output logic [2:0]            state_o,
   output logic                  wdt_trip_o,
   output logic [TRIP_CNT_W-1:0] trip_count_o
);

   localparam int unsigned      CNT_W      = $clog2(max_u(RST_HOLD_CYCLES, FETCH_DELAY) + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_DELAY - 1);
   localparam logic [TRIP_CNT_W-1:0] TRIP_MAX = {TRIP_CNT_W{1'b1}};

   state_t                state_q;
   state_t                state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic [TRIP_CNT_W-1:0] trip_cnt_q;
   logic [TRIP_CNT_W-1:0] trip_cnt_d;
   logic                  wdt_clear;
   logic                  wdt_expired;

   // The watchdog only runs in RUN; holding it cleared elsewhere gives a fresh
   // count on every entry into RUN.
   assign wdt_clear = (state_q != RUN);

   heartbeat_wdt #(
      .WDT_CYCLES (WDT_CYCLES)
   ) u_wdt (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .clear         (wdt_clear),
      .heartbeat_i   (heartbeat_i),
      .expired       (wdt_expired)
   );

   // Next-state, sequencing counter and trip counter. load_req_i is tested
   // first so it wins over terminal counts and watchdog expiry.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      trip_cnt_d = trip_cnt_q;
      case (state_q)
         HOLD: begin
            if (load_req_i) begin
               state_d = LOAD;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = START;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         START: begin
            if (load_req_i) begin
               state_d = LOAD;
               cnt_d   = '0;
            end else if (cnt_q == FETCH_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            cnt_d = '0;
            if (load_req_i) begin
               state_d = LOAD;
            end else if (wdt_enable_i && wdt_expired) begin
               state_d = TRIP;
               if (trip_cnt_q != TRIP_MAX) begin
                  trip_cnt_d = trip_cnt_q + TRIP_CNT_W'(1);
               end else begin
                  trip_cnt_d = trip_cnt_q;
               end
            end else begin
               state_d = RUN;
            end
         end
         LOAD: begin
            cnt_d = '0;
            if (!load_req_i) begin
               state_d = HOLD;
            end else begin
               state_d = LOAD;
            end
         end
         TRIP: begin
            // A trip always completes; a pending load is picked up from HOLD.
            state_d = HOLD;
            cnt_d   = '0;
         end
         default: begin
            state_d = HOLD;
            cnt_d   = '0;
         end
      endcase
   end

   // State, sequencing counter and trip counter registers.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q    <= HOLD;
         cnt_q      <= '0;
         trip_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         trip_cnt_q <= trip_cnt_d;
      end
   end

   // Moore output decode from the registered state.
   always_comb begin
      core_rst_n_o   = 1'b0;
      fetch_enable_o = 1'b0;
      wdt_trip_o     = 1'b0;
      case (state_q)
         HOLD, LOAD: begin
            core_rst_n_o   = 1'b0;
            fetch_enable_o = 1'b0;
         end
         START: begin
            core_rst_n_o   = 1'b1;
            fetch_enable_o = 1'b0;
         end
         RUN: begin
            core_rst_n_o   = 1'b1;
            fetch_enable_o = 1'b1;
         end
         TRIP: begin
            wdt_trip_o     = 1'b1;
         end
         default: begin
            core_rst_n_o   = 1'b0;
            fetch_enable_o = 1'b0;
         end
      endcase
   end

   assign boot_addr_o    = BOOT_ADDR;
   assign testmode_o     = 1'b0;
   assign clock_gating_o = 1'b0;
   assign state_o        = state_q;
   assign trip_count_o   = trip_cnt_q;

endmodule
